// File: rtl/ib_vc.sv
// ib_vc: per-port input buffer with NVC virtual-channel FIFOs and wormhole routing.
// Define IB_DROPCNT_EN to add the saturating 8-bit drops counter output.
module ib_vc #(
    parameter int NPORT = 4,
    parameter int NVC   = 2,
    parameter int DEPTH = 4,
    parameter int DATAW = 32,
    localparam int VCW   = (NVC > 1) ? $clog2(NVC) : 1,
    localparam int FLITW = 2 + VCW + DATAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FLITW-1:0] pkti,
    output logic [NVC-1:0]   full,
    output logic [FLITW-1:0] pkto,
    output logic [NPORT-1:0] req,
    input  logic             ack,
    output logic [VCW-1:0]   vco
`ifdef IB_DROPCNT_EN
    ,
    output logic [7:0]       drops
`endif
);

    localparam int PW   = $clog2(DEPTH);
    localparam int DSTW = (NPORT > 1) ? $clog2(NPORT) : 1;

    localparam logic [1:0] F_IDLE = 2'b00;
    localparam logic [1:0] F_HEAD = 2'b01;
    localparam logic [1:0] F_TAIL = 2'b11;

    localparam logic [PW:0]   CONE  = (PW+1)'(1);
    localparam logic [PW:0]   CFULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PONE  = PW'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [FLITW-1:0] mem [NVC][DEPTH];
    logic [PW-1:0]    wp  [NVC];
    logic [PW-1:0]    rp  [NVC];
    logic [PW:0]      cnt [NVC];
    logic [PW:0]      cnt_nxt [NVC];

    state_t           state;
    logic [VCW-1:0]   active;
    logic [VCW-1:0]   last;

    logic [1:0]       wflow;
    logic [VCW-1:0]   wvc;
    logic             we;
    logic             vc_ok;
    logic             wok;

    logic             found;
    logic [VCW-1:0]   sel;
    logic [VCW-1:0]   cur;
    logic [FLITW-1:0] head;
    logic             cur_ne;
    logic [1:0]       hflow;
    logic [DSTW-1:0]  hdest;
    logic             dest_ok;
    logic             pop_en;
    logic [NVC-1:0]   push;
    logic [NVC-1:0]   pop;

    assign wflow = pkti[FLITW-1 -: 2];
    assign wvc   = pkti[DATAW +: VCW];
    assign we    = (wflow != F_IDLE);
    assign vc_ok = (int'(wvc) < NVC);
    assign wok   = we && vc_ok && !full[wvc];

    // Round-robin scan starting just after the last VC served.
    always_comb begin
        int j;
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int i = 1; i <= NVC; i++) begin
            j = (int'(last) + i) % NVC;
            if (!found && cnt[j] != '0) begin
                found = 1'b1;
                sel   = VCW'(j);
            end
        end
    end

    assign cur     = (state == BUSY) ? active : sel;
    assign head    = mem[cur][rp[cur]];
    assign cur_ne  = (cnt[cur] != '0);
    assign hflow   = head[FLITW-1 -: 2];
    assign hdest   = head[DSTW-1:0];
    assign dest_ok = (int'(hdest) < NPORT);
    assign pkto    = (state == BUSY && cur_ne) ? head : '0;
    assign vco     = active;

    always_comb begin
        pop_en = 1'b0;
        if (state == BUSY)
            pop_en = ack && cur_ne;
        else if (found && (hflow != F_HEAD || !dest_ok))
            pop_en = 1'b1;
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int v = 0; v < NVC; v++) begin
            push[v]    = wok && (wvc == VCW'(v));
            pop[v]     = pop_en && (cur == VCW'(v));
            cnt_nxt[v] = cnt[v];
            if (push[v] && !pop[v])
                cnt_nxt[v] = cnt[v] + CONE;
            else if (!push[v] && pop[v])
                cnt_nxt[v] = cnt[v] - CONE;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NVC; v++)
            if (push[v])
                mem[v][wp[v]] <= pkti;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NVC; v++) begin
                wp[v]  <= '0;
                rp[v]  <= '0;
                cnt[v] <= '0;
            end
            full <= '0;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                if (push[v])
                    wp[v] <= wp[v] + PONE;
                if (pop[v])
                    rp[v] <= rp[v] + PONE;
                cnt[v]  <= cnt_nxt[v];
                full[v] <= (cnt_nxt[v] == CFULL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            req    <= '0;
            active <= '0;
            last   <= VCW'(NVC - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (found && hflow == F_HEAD && dest_ok) begin
                        state  <= BUSY;
                        active <= sel;
                        req    <= NPORT'(1) << hdest;
                    end
                end
                BUSY: begin
                    if (pop_en && hflow == F_TAIL) begin
                        state <= IDLE;
                        req   <= '0;
                        last  <= active;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IB_DROPCNT_EN
    logic       discard;
    logic [1:0] ndrop;
    logic [8:0] dsum;

    assign discard = pop_en && (state == IDLE);
    assign ndrop   = {1'b0, we && !wok} + {1'b0, discard};
    assign dsum    = {1'b0, drops} + {7'b0, ndrop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drops <= '0;
        else
            drops <= dsum[8] ? 8'hff : dsum[7:0];
    end
`endif

endmodule
